// File: rtl/vita49_pkg.sv
// Shared VITA-49 definitions: IF-data header layout, packet state encoding and
// header/beat-count helpers used by both the packetizer and the router.
package vita49_pkg;

  localparam logic [3:0] PKT_TYPE_IF_DATA  = 4'b0001;
  localparam int         MAX_PAYLOAD_BEATS = 32766;
  localparam int         BEAT_W            = 15;

  localparam int STRMID_MSB = 63;
  localparam int STRMID_LSB = 32;
  localparam int TYPE_MSB   = 31;
  localparam int TYPE_LSB   = 28;
  localparam int C_BIT      = 27;
  localparam int T_BIT      = 26;
  localparam int TSI_MSB    = 23;
  localparam int TSI_LSB    = 22;
  localparam int TSF_MSB    = 21;
  localparam int TSF_LSB    = 20;
  localparam int PKTCNT_MSB = 19;
  localparam int PKTCNT_LSB = 16;
  localparam int SIZE_MSB   = 15;
  localparam int SIZE_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2
  } vita49_pkt_state_t;

  function automatic logic [63:0] vita49_mk_hdr(input logic [31:0] strm_id,
                                                input logic [3:0]  pkt_cnt,
                                                input logic [15:0] pkt_size);
    logic [63:0] w_hdr;
    w_hdr                         = '0;
    w_hdr[STRMID_MSB:STRMID_LSB]  = strm_id;
    w_hdr[TYPE_MSB:TYPE_LSB]      = PKT_TYPE_IF_DATA;
    w_hdr[C_BIT]                  = 1'b0;
    w_hdr[T_BIT]                  = 1'b0;
    w_hdr[TSI_MSB:TSI_LSB]        = 2'b00;
    w_hdr[TSF_MSB:TSF_LSB]        = 2'b00;
    w_hdr[PKTCNT_MSB:PKTCNT_LSB]  = pkt_cnt;
    w_hdr[SIZE_MSB:SIZE_LSB]      = pkt_size;
    return w_hdr;
  endfunction

  // Zero is treated as one beat so a packet always carries payload.
  function automatic logic [BEAT_W-1:0] vita49_eff_beats(input logic [15:0] cfg);
    if (cfg == 16'd0)
      return BEAT_W'(1);
    else if (cfg > 16'(MAX_PAYLOAD_BEATS))
      return BEAT_W'(MAX_PAYLOAD_BEATS);
    else
      return cfg[BEAT_W-1:0];
  endfunction

endpackage

// File: rtl/vita49_axis_oreg.sv
// Single-entry registered AXI-Stream output stage: accepts a new beat whenever
// it is empty or the downstream consumes the current one.
module vita49_axis_oreg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_can_load
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  assign o_can_load = !r_valid || i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;

  // Clear drops the pending beat outright; downstream tolerates a truncated packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (o_can_load) begin
      r_valid <= i_load;
      if (i_load) begin
        r_data <= i_data;
        r_last <= i_last;
      end
    end
  end

endmodule

// File: rtl/vita49_packetizer.sv
// Frames a raw 64-bit sample stream into VITA-49 IF-data packets: one header
// beat followed by a configurable number of payload beats.
module vita49_packetizer
  import vita49_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [63:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic [7:0]       M_AXIS_TSTRB,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  input  logic [31:0]      cmd,
  input  logic [31:0]      strmID,
  input  logic [15:0]      cfg_beats,
  output logic [CNT_W-1:0] pkt_sent,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  vita49_pkt_state_t r_state, w_next_state;

  logic [BEAT_W-1:0] r_eff_beats;
  logic [BEAT_W-1:0] r_beat_rem;
  logic [15:0]       r_pkt_size;
  logic [31:0]       r_strm_id;
  logic [3:0]        r_pkt_cnt;
  logic [CNT_W-1:0]  r_pkt_sent;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_run;
  logic              w_abort;
  logic              w_can_load;
  logic              w_tready;
  logic              w_pay_xfer;
  logic              w_last_beat;
  logic              w_oload;
  logic [63:0]       w_odata;
  logic              w_olast;
  logic              w_latch;
  logic [BEAT_W-1:0] w_eff_beats;
  logic              w_unused;

  assign w_run       = cmd[0];
  assign w_abort     = cmd[1];
  assign w_unused    = ^cmd[31:2];
  assign w_eff_beats = vita49_eff_beats(cfg_beats);
  assign w_last_beat = (r_beat_rem == BEAT_W'(1));

  // Ready is withheld during an abort so no sample is swallowed by a dropped packet.
  assign w_tready   = (r_state == S_PAYLOAD) && w_can_load && !w_abort;
  assign w_pay_xfer = w_tready && S_AXIS_TVALID;

  assign S_AXIS_TREADY = w_tready;
  assign M_AXIS_TSTRB  = 8'hff;
  assign pkt_sent      = r_pkt_sent;
  assign drop_cnt      = r_drop_cnt;
  assign busy          = (r_state != S_IDLE);

  always_comb begin
    w_next_state = r_state;
    w_oload      = 1'b0;
    w_odata      = S_AXIS_TDATA;
    w_olast      = 1'b0;
    w_latch      = 1'b0;
    if (w_abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_run && w_can_load) begin
            w_latch      = 1'b1;
            w_next_state = S_HDR;
          end
        end
        S_HDR: begin
          if (w_can_load) begin
            w_oload      = 1'b1;
            w_odata      = vita49_mk_hdr(r_strm_id, r_pkt_cnt, r_pkt_size);
            w_next_state = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_pay_xfer) begin
            w_oload = 1'b1;
            w_olast = w_last_beat;
            if (w_last_beat) begin
              w_latch      = w_run;
              w_next_state = w_run ? S_HDR : S_IDLE;
            end
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Packet parameters are captured only at packet start, so mid-packet config edits wait.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state     <= S_IDLE;
      r_eff_beats <= '0;
      r_beat_rem  <= '0;
      r_pkt_size  <= '0;
      r_strm_id   <= '0;
      r_pkt_cnt   <= '0;
      r_pkt_sent  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_abort)
        r_beat_rem <= '0;
      else if (r_state == S_HDR && w_can_load)
        r_beat_rem <= r_eff_beats;
      else if (w_pay_xfer)
        r_beat_rem <= r_beat_rem - BEAT_W'(1);
      if (w_latch) begin
        r_eff_beats <= w_eff_beats;
        r_pkt_size  <= 16'd2 + {w_eff_beats, 1'b0};
        r_strm_id   <= strmID;
      end
      if (w_pay_xfer && w_last_beat) begin
        r_pkt_cnt  <= r_pkt_cnt + 4'd1;
        r_pkt_sent <= r_pkt_sent + CNT_W'(1);
      end
      if (w_pay_xfer && !w_last_beat && S_AXIS_TLAST)
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  vita49_axis_oreg #(
    .DATA_W (64)
  ) u_oreg (
    .clk        (AXIS_ACLK),
    .rst_n      (AXIS_ARESETN),
    .i_clear    (w_abort),
    .i_load     (w_oload),
    .i_data     (w_odata),
    .i_last     (w_olast),
    .i_ready    (M_AXIS_TREADY),
    .o_valid    (M_AXIS_TVALID),
    .o_data     (M_AXIS_TDATA),
    .o_last     (M_AXIS_TLAST),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_vita49_packetizer.sv
// Self-checking bench for vita49_packetizer: randomized sample streams compared
// against a packet-level model of the expected output beat sequence.
module tb_vita49_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic [7:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tready;
  logic [31:0] cmd;
  logic [31:0] strm;
  logic [15:0] cfg;
  logic [31:0] pkt_sent;
  logic [31:0] drop_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [63:0] in_q[$];
  bit          in_tl_q[$];
  logic [63:0] out_q[$];
  bit          out_last_q[$];
  int          out_cyc_q[$];
  int          cyc;
  int          stall_err;
  bit          prev_stall;
  logic [63:0] prev_data;
  logic        prev_last;

  vita49_packetizer #(.CNT_W(32)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .cmd           (cmd),
    .strmID        (strm),
    .cfg_beats     (cfg),
    .pkt_sent      (pkt_sent),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Header of packet number pkt_no for a given configured beat count.
  function automatic logic [63:0] exp_hdr(input logic [31:0] sid, input int pkt_no, input int beats);
    int eff;
    eff = (beats == 0) ? 1 : ((beats > 32766) ? 32766 : beats);
    return {sid, 4'h1, 8'h00, 4'(pkt_no % 16), 16'(2 + 2 * eff)};
  endfunction

  // One clock: drive after the edge, observe handshakes at the falling edge.
  task automatic drive_cycle(input bit v, input bit r, input logic [63:0] d, input bit tl,
                             input logic [31:0] c);
    @(posedge clk);
    #1;
    s_tvalid = v; m_tready = r; s_tdata = d; s_tlast = tl; cmd = c;
    cyc++;
    @(negedge clk);
    if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last)) stall_err++;
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (s_tvalid && s_tready) begin
      in_q.push_back(s_tdata);
      in_tl_q.push_back(s_tlast);
    end
    if (m_tvalid && m_tready) begin
      out_q.push_back(m_tdata);
      out_last_q.push_back(m_tlast);
      out_cyc_q.push_back(cyc);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0; cmd = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    in_q.delete(); in_tl_q.delete(); out_q.delete(); out_last_q.delete(); out_cyc_q.delete();
    prev_stall = 1'b0; stall_err = 0; cyc = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 64'h1234; m_tready = 1'b1;
    cmd = 32'd1; cfg = 16'd3; strm = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0h exp=0", m_tvalid); end
    checks++; if (m_tdata !== 64'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%0h exp=0", m_tlast); end
    checks++; if (m_tstrb !== 8'hff) begin failures++; $display("FAIL reset_tstrb got=%h exp=ff", m_tstrb); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%0h exp=0", s_tready); end
    checks++; if (pkt_sent !== 32'd0) begin failures++; $display("FAIL reset_pkt_sent got=%0d exp=0", pkt_sent); end
    checks++; if (drop_cnt !== 32'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_basic;
    do_reset();
    cfg = 16'd3; strm = 32'hA5A5_0001;
    for (int i = 0; i < 40 && out_q.size() < 8; i++) drive_cycle(1, 1, {$urandom, $urandom}, 0, 32'd1);
    checks++;
    if (out_q.size() < 8) begin
      failures++; $display("FAIL basic_timeout got=%0d beats exp=8", out_q.size()); return;
    end
    checks++; if (out_q[0] !== 64'hA5A5_0001_1000_0008) begin failures++; $display("FAIL basic_hdr0 got=%h exp=a5a5000110000008", out_q[0]); end
    checks++; if (out_last_q[0] !== 1'b0) begin failures++; $display("FAIL basic_hdr0_last got=%0d exp=0", out_last_q[0]); end
    for (int j = 1; j <= 3; j++) begin
      checks++; if (out_q[j] !== in_q[j-1]) begin failures++; $display("FAIL basic_payload%0d got=%h exp=%h", j, out_q[j], in_q[j-1]); end
      checks++; if (out_last_q[j] !== (j == 3)) begin failures++; $display("FAIL basic_last%0d got=%0d exp=%0d", j, out_last_q[j], (j == 3)); end
    end
    checks++; if (out_q[4] !== 64'hA5A5_0001_1001_0008) begin failures++; $display("FAIL basic_hdr1 got=%h exp=a5a5000110010008", out_q[4]); end
    checks++; if (out_cyc_q[4] !== out_cyc_q[3] + 1) begin failures++; $display("FAIL basic_no_bubble got=%0d exp=%0d", out_cyc_q[4], out_cyc_q[3] + 1); end
  endtask

  task automatic test_pktcnt;
    do_reset();
    cfg = 16'd1; strm = $urandom;
    for (int i = 0; i < 400 && out_q.size() < 34; i++)
      drive_cycle(in_q.size() < 17, 1, {$urandom, $urandom}, 0, {31'd0, in_q.size() < 17});
    repeat (3) drive_cycle(0, 1, 64'h0, 0, 32'd0);
    checks++;
    if (out_q.size() < 34 || in_q.size() != 17) begin
      failures++; $display("FAIL pktcnt_timeout got=%0d beats exp=34", out_q.size()); return;
    end
    for (int p = 0; p < 17; p++) begin
      checks++; if (out_q[2*p] !== exp_hdr(strm, p, 1)) begin failures++; $display("FAIL pktcnt_hdr%0d got=%h exp=%h", p, out_q[2*p], exp_hdr(strm, p, 1)); end
      checks++; if (out_q[2*p+1] !== in_q[p]) begin failures++; $display("FAIL pktcnt_data%0d got=%h exp=%h", p, out_q[2*p+1], in_q[p]); end
      checks++; if (out_last_q[2*p+1] !== 1'b1) begin failures++; $display("FAIL pktcnt_last%0d got=%0d exp=1", p, out_last_q[2*p+1]); end
    end
    checks++; if (pkt_sent !== 32'd17) begin failures++; $display("FAIL pktcnt_sent got=%0d exp=17", pkt_sent); end
  endtask

  task automatic test_random;
    int exp_drop;
    logic [63:0] exp_d;
    do_reset();
    cfg = 16'd5; strm = $urandom;
    for (int i = 0; i < 3000 && out_q.size() < 120; i++)
      drive_cycle((in_q.size() < 100) && ($urandom % 2 == 1), $urandom % 2 == 1,
                  {$urandom, $urandom}, $urandom % 4 == 0, 32'd1);
    repeat (3) drive_cycle(0, 1, 64'h0, 0, 32'd0);
    checks++;
    if (out_q.size() < 120 || in_q.size() != 100) begin
      failures++; $display("FAIL random_timeout got=%0d beats exp=120", out_q.size()); return;
    end
    for (int k = 0; k < 120; k++) begin
      exp_d = (k % 6 == 0) ? exp_hdr(strm, k / 6, 5) : in_q[(k / 6) * 5 + (k % 6) - 1];
      checks++; if (out_q[k] !== exp_d) begin failures++; $display("FAIL random_data%0d got=%h exp=%h", k, out_q[k], exp_d); end
      checks++; if (out_last_q[k] !== (k % 6 == 5)) begin failures++; $display("FAIL random_last%0d got=%0d exp=%0d", k, out_last_q[k], (k % 6 == 5)); end
    end
    exp_drop = 0;
    foreach (in_tl_q[i]) if (in_tl_q[i] && (i % 5 != 4)) exp_drop++;
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL random_stall_stable got=%0d exp=0", stall_err); end
    checks++; if (pkt_sent !== 32'd20) begin failures++; $display("FAIL random_pkt_sent got=%0d exp=20", pkt_sent); end
    checks++; if (drop_cnt !== 32'(exp_drop)) begin failures++; $display("FAIL random_drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop); end
  endtask

  task automatic test_beat_limits;
    int lasts;
    do_reset();
    cfg = 16'd0; strm = $urandom;
    for (int i = 0; i < 20 && out_q.size() < 2; i++) drive_cycle(1, 1, {$urandom, $urandom}, 0, 32'd1);
    checks++;
    if (out_q.size() < 2) begin
      failures++; $display("FAIL zero_timeout got=%0d beats exp=2", out_q.size());
    end else begin
      checks++; if (out_q[0] !== exp_hdr(strm, 0, 0)) begin failures++; $display("FAIL zero_hdr got=%h exp=%h", out_q[0], exp_hdr(strm, 0, 0)); end
      checks++; if (out_last_q[1] !== 1'b1) begin failures++; $display("FAIL zero_last got=%0d exp=1", out_last_q[1]); end
    end
    do_reset();
    cfg = 16'hFFFF; strm = $urandom;
    for (int i = 0; i < 33000 && out_q.size() < 32768; i++)
      drive_cycle(in_q.size() < 32766, 1, {$urandom, $urandom}, 0, 32'd1);
    checks++;
    if (out_q.size() < 32768) begin
      failures++; $display("FAIL max_timeout got=%0d beats exp=32768", out_q.size()); return;
    end
    lasts = 0;
    for (int k = 1; k <= 32766; k++) if (out_last_q[k]) lasts++;
    checks++; if (out_q[0][15:0] !== 16'hFFFE) begin failures++; $display("FAIL max_size got=%h exp=fffe", out_q[0][15:0]); end
    checks++; if (out_last_q[32766] !== 1'b1) begin failures++; $display("FAIL max_last got=%0d exp=1", out_last_q[32766]); end
    checks++; if (lasts !== 1) begin failures++; $display("FAIL max_last_count got=%0d exp=1", lasts); end
    checks++; if (out_q[32767] !== exp_hdr(strm, 1, 65535)) begin failures++; $display("FAIL max_hdr1 got=%h exp=%h", out_q[32767], exp_hdr(strm, 1, 65535)); end
  endtask

  task automatic test_stop;
    do_reset();
    cfg = 16'd4; strm = $urandom;
    for (int i = 0; i < 30; i++)
      drive_cycle(1, 1, {$urandom, $urandom}, in_q.size() == 1, {31'd0, in_q.size() < 1});
    checks++;
    if (out_q.size() !== 5) begin
      failures++; $display("FAIL stop_beats got=%0d exp=5", out_q.size()); return;
    end
    checks++; if (out_q[0] !== exp_hdr(strm, 0, 4)) begin failures++; $display("FAIL stop_hdr got=%h exp=%h", out_q[0], exp_hdr(strm, 0, 4)); end
    checks++; if (out_q[4] !== in_q[3]) begin failures++; $display("FAIL stop_data got=%h exp=%h", out_q[4], in_q[3]); end
    checks++; if (out_last_q[4] !== 1'b1 || out_last_q[3] !== 1'b0) begin failures++; $display("FAIL stop_last got=%0d%0d exp=01", out_last_q[3], out_last_q[4]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%0d exp=0", busy); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL stop_tready got=%0d exp=0", s_tready); end
    checks++; if (drop_cnt !== 32'd1) begin failures++; $display("FAIL stop_drop got=%0d exp=1", drop_cnt); end
    checks++; if (pkt_sent !== 32'd1) begin failures++; $display("FAIL stop_sent got=%0d exp=1", pkt_sent); end
  endtask

  task automatic test_abort;
    int base_out;
    int base_in;
    do_reset();
    cfg = 16'd2; strm = $urandom;
    for (int i = 0; i < 40 && in_q.size() < 3; i++) drive_cycle(1, 1, {$urandom, $urandom}, 0, 32'd1);
    drive_cycle(1, 1, {$urandom, $urandom}, 0, 32'd3);
    drive_cycle(1, 1, {$urandom, $urandom}, 0, 32'd3);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL abort_tvalid got=%0d exp=0", m_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0d exp=0", busy); end
    checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL abort_tready got=%0d exp=0", s_tready); end
    checks++; if (pkt_sent !== 32'd1) begin failures++; $display("FAIL abort_sent got=%0d exp=1", pkt_sent); end
    base_out = out_q.size();
    base_in  = in_q.size();
    for (int i = 0; i < 20 && out_q.size() < base_out + 2; i++) drive_cycle(1, 1, {$urandom, $urandom}, 0, 32'd1);
    checks++;
    if (out_q.size() < base_out + 2) begin
      failures++; $display("FAIL abort_restart_timeout got=%0d exp=%0d", out_q.size(), base_out + 2); return;
    end
    checks++; if (out_q[base_out] !== exp_hdr(strm, 1, 2)) begin failures++; $display("FAIL abort_restart_hdr got=%h exp=%h", out_q[base_out], exp_hdr(strm, 1, 2)); end
    checks++; if (out_q[base_out+1] !== in_q[base_in]) begin failures++; $display("FAIL abort_restart_data got=%h exp=%h", out_q[base_out+1], in_q[base_in]); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prereset_busy got=%0d exp=1", busy); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL areset_tvalid got=%0d exp=0", m_tvalid); end
    checks++; if (m_tdata !== 64'h0) begin failures++; $display("FAIL areset_tdata got=%h exp=0", m_tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%0d exp=0", busy); end
    checks++; if (pkt_sent !== 32'd0) begin failures++; $display("FAIL areset_sent got=%0d exp=0", pkt_sent); end
    checks++; if (m_tstrb !== 8'hff) begin failures++; $display("FAIL areset_tstrb got=%h exp=ff", m_tstrb); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pktcnt();
    test_random();
    test_beat_limits();
    test_stop();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vita49_packetizer.md
Name: vita49_packetizer

Overview:
- Upstream neighbour of the VITA-49 router. Takes a raw 64-bit sample stream and emits VITA-49 IF-data packets.
- Each packet is one 64-bit header beat followed by a fixed number of payload beats; M_AXIS_TLAST is asserted on the final payload beat.
- The output format is exactly what the router parses: header word with streamID in [63:32], packet size counted in 32-bit words including the 2-word header.

Parameters:
- CNT_W, 32, width of the status counters pkt_sent and drop_cnt.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXIS_TDATA  in  64  sample data (two 32-bit IQ words per beat).
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TLAST  in  1  ignored for framing; only counted when it arrives mid-packet.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  64  header or payload beat.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TSTRB  out  8  constant 8'hff.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TREADY  in  1  downstream ready.
- cmd  in  32  bit0 start/run (level), bit1 abort; other bits ignored.
- strmID  in  32  stream ID written into each header.
- cfg_beats  in  16  payload beats per packet, sampled at each packet start.
- pkt_sent  out  CNT_W  packets completed; wraps at full width.
- drop_cnt  out  CNT_W  count of input TLASTs seen before the final payload beat.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values: all outputs 0, except M_AXIS_TSTRB = 8'hff. State = IDLE; pkt_cnt = 0.
- Output stage is a single register (ovalid, odata, olast).
  - Loads when !ovalid | M_AXIS_TREADY.
  - Holds stable while ovalid & !M_AXIS_TREADY.
  - Full throughput: one beat per cycle when TREADY is held high.
- Beat count: eff_beats = (cfg_beats == 0) ? 1 : min(cfg_beats, 32766). pkt_size = 2 + 2*eff_beats (16 bits, never overflows).
- Header word:
  - [63:32] = strmID
  - [31:28] = 4'b0001
  - [27:24] = 0 (C, T, reserved)
  - [23:20] = 0 (TSI, TSF)
  - [19:16] = pkt_cnt
  - [15:0] = pkt_size
  - strmID is sampled in the same cycle as cfg_beats.
- State IDLE:
  - S_AXIS_TREADY = 0.
  - If cmd[0] and output stage loadable: latch eff_beats, pkt_size and strmID, then go to HDR.
- State HDR:
  - When the output stage is loadable: load the header beat with olast = 0, set beat_rem = eff_beats, go to PAYLOAD.
  - The header is therefore visible on M_AXIS one cycle after the load.
- State PAYLOAD:
  - S_AXIS_TREADY = !ovalid | M_AXIS_TREADY.
  - On each input transfer: load odata = S_AXIS_TDATA, olast = (beat_rem == 1), decrement beat_rem.
  - On the transfer with beat_rem == 1: pkt_cnt++ (4-bit, wraps 15→0), pkt_sent++.
  - Next state after the last beat: HDR if cmd[0], else IDLE.
  - S_AXIS_TLAST on any non-final beat increments drop_cnt; the packet continues unchanged.
- Latency: one cycle from input transfer to the beat appearing on M_AXIS. No bubble between packets: the header is loaded the cycle after the last payload beat is loaded.
- cmd[0] deasserted mid-packet: the current packet completes, then IDLE.
- cmd[1] abort (synchronous, highest priority):
  - Next cycle: state = IDLE, ovalid = 0, beat_rem = 0, S_AXIS_TREADY = 0.
  - pkt_cnt, pkt_sent and drop_cnt are kept.
  - A truncated packet downstream is accepted; the router resynchronises on its next header.
- cmd[0] and cmd[1] both set: abort wins. Start is honoured once cmd[1] clears.
- cfg_beats or strmID changing mid-packet has no effect until the next packet start.
- Asynchronous reset mid-packet: immediate return to reset values.

Decomposition:
- Shared package vita49_pkg holds:
  - PKT_TYPE_IF_DATA = 4'b0001
  - header field bit positions (STRMID_MSB/LSB, TYPE, C, T, TSI, TSF, PKTCNT, SIZE)
  - MAX_PAYLOAD_BEATS = 32766
  - the function vita49_mk_hdr(strmID, pkt_cnt, pkt_size)
- The router side should reuse the same package.
- One natural sub-module: vita49_axis_oreg, the single-entry registered AXIS output stage (data, last, valid/ready).

Test Plan:
- cfg_beats = 3, strmID = 32'hA5A5_0001, cmd = 1, continuous input, TREADY = 1 → header 64'hA5A5_0001_1000_0008, then 3 payload beats with TLAST on the 3rd; the next header carries pkt_cnt = 1 (64'hA5A5_0001_1001_0008) with no idle cycle.
- 17 packets with cfg_beats = 1 → pkt_cnt sequence 0..15, 0; pkt_size field = 4; pkt_sent = 17.
- Random TREADY (50%) and random TVALID, cfg_beats = 5 → output data equals input in order, with headers every 6 beats; no beat lost or duplicated; TDATA held stable while stalled.
- cfg_beats = 0 → pkt_size = 4 with 1 payload beat; cfg_beats = 16'hFFFF → pkt_size = 16'hFFFE, TLAST after 32766 beats.
- Clear cmd[0] at the 2nd payload beat of a 4-beat packet → packet completes with TLAST, busy falls, S_AXIS_TREADY = 0 afterwards; input TLAST on beat 2 → drop_cnt = 1.
- Pulse cmd[1] mid-payload → next cycle M_AXIS_TVALID = 0 and state IDLE; on restart the header pkt_cnt continues from its prior value; asynchronous reset mid-packet → all outputs 0 immediately.
